dispatch: RTL

DISPATCH -- requirements
Module: dispatch

---
 rtl/dispatch_pkg.sv | 34 +++
 rtl/dispatch_if.sv | 40 ++++
 rtl/scoreboard.sv | 58 +++++
 rtl/dispatch.sv | 92 +++++++++
 4 files changed

// File: rtl/dispatch_pkg.sv
// Shared types and constants for the dual-issue dispatch stage.
package dispatch_pkg;
  localparam int NUM_SLOTS = 2;
  localparam int SB_CNT_W  = 2;
  localparam int SB_DEPTH  = 32;
  localparam int RD_PORTS  = 2 * NUM_SLOTS;

  localparam logic [2:0] ALUSEL_NOP   = 3'b000;
  localparam logic [2:0] ALUSEL_LOGIC = 3'b001;
  localparam logic [2:0] ALUSEL_SHIFT = 3'b010;
  localparam logic [2:0] ALUSEL_ARITH = 3'b100;

  localparam logic [7:0] ALUOP_NOP = 8'h00;
  localparam logic [7:0] ALUOP_AND = 8'h24;
  localparam logic [7:0] ALUOP_OR  = 8'h25;
  localparam logic [7:0] ALUOP_ADD = 8'h20;
  localparam logic [7:0] ALUOP_SUB = 8'h22;
  localparam logic [7:0] ALUOP_SLL = 8'h7c;

  // One decoded instruction as it travels from the queue head to execute.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] imm;
    logic        reg_write_en;
    logic        reg1_read_en;
    logic        reg2_read_en;
    logic [4:0]  reg1_read_addr;
    logic [4:0]  reg2_read_addr;
    logic [4:0]  reg_write_addr;
  } dec_inst_t;
endpackage

// File: rtl/dispatch_if.sv
// Queue-head / execute / writeback bundle around the dispatch stage.
interface dispatch_if;
  import dispatch_pkg::*;
  logic [1:0]       in_valid;
  logic [1:0][31:0] in_pc, in_inst, in_imm;
  logic [1:0][7:0]  in_aluop;
  logic [1:0][2:0]  in_alusel;
  logic [1:0]       in_reg_write_en, in_reg1_read_en, in_reg2_read_en;
  logic [1:0][4:0]  in_reg1_read_addr, in_reg2_read_addr, in_reg_write_addr;
  logic             ex_ready;
  logic [1:0]       wb_en;
  logic [1:0][4:0]  wb_addr;
  logic [1:0]       consume;
  logic [1:0]       issue_valid;
  logic [1:0][31:0] issue_pc, issue_inst, issue_imm;
  logic [1:0][7:0]  issue_aluop;
  logic [1:0][2:0]  issue_alusel;
  logic [1:0]       issue_reg_write_en, issue_reg1_read_en, issue_reg2_read_en;
  logic [1:0][4:0]  issue_reg1_read_addr, issue_reg2_read_addr, issue_reg_write_addr;

  modport slave (
    input  in_valid, in_pc, in_inst, in_imm, in_aluop, in_alusel,
           in_reg_write_en, in_reg1_read_en, in_reg2_read_en,
           in_reg1_read_addr, in_reg2_read_addr, in_reg_write_addr,
           ex_ready, wb_en, wb_addr,
    output consume, issue_valid, issue_pc, issue_inst, issue_imm, issue_aluop,
           issue_alusel, issue_reg_write_en, issue_reg1_read_en, issue_reg2_read_en,
           issue_reg1_read_addr, issue_reg2_read_addr, issue_reg_write_addr
  );

  modport master (
    output in_valid, in_pc, in_inst, in_imm, in_aluop, in_alusel,
           in_reg_write_en, in_reg1_read_en, in_reg2_read_en,
           in_reg1_read_addr, in_reg2_read_addr, in_reg_write_addr,
           ex_ready, wb_en, wb_addr,
    input  consume, issue_valid, issue_pc, issue_inst, issue_imm, issue_aluop,
           issue_alusel, issue_reg_write_en, issue_reg1_read_en, issue_reg2_read_en,
           issue_reg1_read_addr, issue_reg2_read_addr, issue_reg_write_addr
  );
endinterface

// File: rtl/scoreboard.sv
// Pending-write scoreboard: a saturating counter per architectural register.
// Entry 0 is hardwired to zero so r0 never creates a dependency.
module scoreboard
  import dispatch_pkg::*;
(
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic [NUM_SLOTS-1:0]               set_en,
  input  logic [NUM_SLOTS-1:0][4:0]          set_addr,
  input  logic [NUM_SLOTS-1:0]               clr_en,
  input  logic [NUM_SLOTS-1:0][4:0]          clr_addr,
  input  logic [RD_PORTS-1:0][4:0]           rd_addr,
  output logic [RD_PORTS-1:0][SB_CNT_W-1:0]  rd_cnt,
  output logic [NUM_SLOTS-1:0]               set_full
);
  localparam int NW = SB_CNT_W + 2;
  localparam logic signed [NW-1:0] CNT_MAX = NW'((1 << SB_CNT_W) - 1);

  logic [SB_CNT_W-1:0] cnt     [SB_DEPTH];
  logic [SB_CNT_W-1:0] cnt_nxt [SB_DEPTH];

  // Read ports; full flags look at the current count (before this edge's updates).
  always_comb begin
    for (int r = 0; r < RD_PORTS; r++)
      rd_cnt[r] = (rd_addr[r] == 5'd0) ? '0 : cnt[rd_addr[r]];
    for (int s = 0; s < NUM_SLOTS; s++)
      set_full[s] = (set_addr[s] != 5'd0) && (cnt[set_addr[s]] == '1);
  end

  // Net of all increments/decrements hitting an entry, clamped to the counter range.
  always_comb begin
    logic signed [NW-1:0] net;
    net = '0;
    for (int e = 0; e < SB_DEPTH; e++) begin
      net = signed'(NW'(cnt[e]));
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (set_en[s] && set_addr[s] == 5'(e)) net = net + NW'(1);
        if (clr_en[s] && clr_addr[s] == 5'(e)) net = net - NW'(1);
      end
      if (net < 0)            cnt_nxt[e] = '0;
      else if (net > CNT_MAX) cnt_nxt[e] = '1;
      else                    cnt_nxt[e] = net[SB_CNT_W-1:0];
    end
    cnt_nxt[0] = '0;
  end

  // Counter state; flush wipes everything regardless of pending updates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e < SB_DEPTH; e++) cnt[e] <= '0;
    end else if (flush) begin
      for (int e = 0; e < SB_DEPTH; e++) cnt[e] <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end
endmodule

// File: rtl/dispatch.sv
// Dual in-order issue stage: checks the two queue-head slots against the
// scoreboard, pops what can go, and registers the issue bundle for execute.
module dispatch
  import dispatch_pkg::*;
(
  input logic        clk,
  input logic        rst,
  input logic        flush,
  dispatch_if.slave  bus
);
  logic [NUM_SLOTS-1:0]              src_ok, dst_ok, slot_ok, take, set_en;
  logic [RD_PORTS-1:0][4:0]          rd_addr;
  logic [RD_PORTS-1:0][SB_CNT_W-1:0] rd_cnt;
  logic [NUM_SLOTS-1:0]              set_full;
  logic                              raw_hazard, can_issue;
  dec_inst_t [NUM_SLOTS-1:0]         slot_in, slot_q;
  logic [NUM_SLOTS-1:0]              vld_q;

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    assign slot_in[i] = '{
      pc:             bus.in_pc[i],
      inst:           bus.in_inst[i],
      aluop:          bus.in_aluop[i],
      alusel:         bus.in_alusel[i],
      imm:            bus.in_imm[i],
      reg_write_en:   bus.in_reg_write_en[i],
      reg1_read_en:   bus.in_reg1_read_en[i],
      reg2_read_en:   bus.in_reg2_read_en[i],
      reg1_read_addr: bus.in_reg1_read_addr[i],
      reg2_read_addr: bus.in_reg2_read_addr[i],
      reg_write_addr: bus.in_reg_write_addr[i]
    };
    assign rd_addr[2*i]   = slot_in[i].reg1_read_addr;
    assign rd_addr[2*i+1] = slot_in[i].reg2_read_addr;
    assign src_ok[i]  = (!slot_in[i].reg1_read_en || rd_cnt[2*i]   == '0) &&
                        (!slot_in[i].reg2_read_en || rd_cnt[2*i+1] == '0);
    assign dst_ok[i]  = !slot_in[i].reg_write_en || !set_full[i];
    assign slot_ok[i] = bus.in_valid[i] && src_ok[i] && dst_ok[i];
    assign set_en[i]  = take[i] && slot_in[i].reg_write_en;

    assign bus.issue_pc[i]             = slot_q[i].pc;
    assign bus.issue_inst[i]           = slot_q[i].inst;
    assign bus.issue_aluop[i]          = slot_q[i].aluop;
    assign bus.issue_alusel[i]         = slot_q[i].alusel;
    assign bus.issue_imm[i]            = slot_q[i].imm;
    assign bus.issue_reg_write_en[i]   = slot_q[i].reg_write_en;
    assign bus.issue_reg1_read_en[i]   = slot_q[i].reg1_read_en;
    assign bus.issue_reg2_read_en[i]   = slot_q[i].reg2_read_en;
    assign bus.issue_reg1_read_addr[i] = slot_q[i].reg1_read_addr;
    assign bus.issue_reg2_read_addr[i] = slot_q[i].reg2_read_addr;
    assign bus.issue_reg_write_addr[i] = slot_q[i].reg_write_addr;
  end

  // Intra-pair RAW: slot 1 may not read what slot 0 is about to write (r0 exempt).
  always_comb begin
    raw_hazard = slot_in[0].reg_write_en && slot_in[0].reg_write_addr != 5'd0 &&
                 ((slot_in[1].reg1_read_en && slot_in[1].reg1_read_addr == slot_in[0].reg_write_addr) ||
                  (slot_in[1].reg2_read_en && slot_in[1].reg2_read_addr == slot_in[0].reg_write_addr));
    can_issue  = bus.ex_ready && !flush && !rst;
    take[0]    = can_issue && slot_ok[0];
    take[1]    = take[0] && slot_ok[1] && !raw_hazard;
  end

  assign bus.consume     = take;
  assign bus.issue_valid = vld_q;

  // Issue register: loads whenever execute accepts; flush only kills the valids.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      slot_q <= '0;
    end else if (flush) begin
      vld_q  <= '0;
    end else if (bus.ex_ready) begin
      vld_q  <= take;
      slot_q <= slot_in;
    end
  end

  scoreboard u_sb (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .set_en   (set_en),
    .set_addr ({slot_in[1].reg_write_addr, slot_in[0].reg_write_addr}),
    .clr_en   (bus.wb_en),
    .clr_addr (bus.wb_addr),
    .rd_addr  (rd_addr),
    .rd_cnt   (rd_cnt),
    .set_full (set_full)
  );
endmodule
